// File: rtl/mobo_mem_responder_pkg.sv
// Shared CPU<->motherboard handshake codes and responder state encoding.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

package mobo_pkg;

  // Command codes driven by the CPU on mobo_ctrl.
  localparam int unsigned CTRL_NONE  = 0;
  localparam int unsigned CTRL_READ  = 1;
  localparam int unsigned CTRL_WRITE = 2;

  // Status codes reported on mobo_stat.
  localparam int unsigned STAT_IDLE = 0;
  localparam int unsigned STAT_BUSY = 1;
  localparam int unsigned STAT_DONE = 2;
  localparam int unsigned STAT_ERR  = 3;

  // Responder states; encoding equals the status code so mobo_stat is the state register.
  typedef logic [1:0] resp_state_t;
  localparam resp_state_t ST_IDLE = 2'(STAT_IDLE);
  localparam resp_state_t ST_BUSY = 2'(STAT_BUSY);
  localparam resp_state_t ST_DONE = 2'(STAT_DONE);
  localparam resp_state_t ST_ERR  = 2'(STAT_ERR);

  // Bit width needed to index n values, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mobo_mem_responder_sram.sv
// Single-port synchronous word RAM; array is not reset.
module mobo_sram #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  output logic [WORD_WIDTH-1:0] o_rdata
);

  logic [WORD_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [WORD_WIDTH-1:0] r_rdata;

  // Write on enable; read-first registered read every cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mobo_mem_responder.sv
// Memory-side responder of the CPU<->motherboard four-phase ctrl/stat handshake.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module mobo_mem_responder
  import mobo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = `WORD_WIDTH,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WORD_WIDTH-1:0] i_mobo_ctrl,
  output logic [WORD_WIDTH-1:0] o_mobo_stat,
  input  logic [WORD_WIDTH-1:0] i_cpu_addr,
  input  logic [WORD_WIDTH-1:0] i_cpu_wdata,
  output logic [WORD_WIDTH-1:0] o_cpu_rdata
);

  localparam int unsigned ADDR_WIDTH = clog2_min1(MEM_DEPTH);
  localparam int unsigned CNT_WIDTH  = clog2_min1(WAIT_CYCLES + 1);

  resp_state_t           r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_is_write;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [WORD_WIDTH-1:0] r_rdata;

  logic                  w_is_read_cmd;
  logic                  w_is_write_cmd;
  logic                  w_is_none_cmd;
  logic                  w_oob;
  logic                  w_finish;
  logic                  w_sram_we;
  logic [ADDR_WIDTH-1:0] w_sram_addr;
  logic [WORD_WIDTH-1:0] w_sram_rdata;

  // Command decode, range check and memory control.
  always_comb begin
    w_is_read_cmd  = (i_mobo_ctrl == WORD_WIDTH'(CTRL_READ));
    w_is_write_cmd = (i_mobo_ctrl == WORD_WIDTH'(CTRL_WRITE));
    w_is_none_cmd  = (i_mobo_ctrl == WORD_WIDTH'(CTRL_NONE));
    w_oob          = (r_addr >= WORD_WIDTH'(MEM_DEPTH));
    w_finish       = (r_state == ST_BUSY) && (r_cnt == '0);
    // Reset on the completing edge must abort the write as well.
    w_sram_we      = w_finish && r_is_write && !w_oob && !i_rst;
    // In IDLE the RAM already looks at the incoming address so read data is
    // ready at the completing edge even with zero wait cycles.
    w_sram_addr    = (r_state == ST_IDLE) ? i_cpu_addr[ADDR_WIDTH-1:0]
                                          : r_addr[ADDR_WIDTH-1:0];
  end

  mobo_sram #(
    .WORD_WIDTH (WORD_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .i_clk   (i_clk),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_sram_rdata)
  );

  // Handshake FSM, wait counter, request latches and read-data register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_read_cmd || w_is_write_cmd) begin
            r_is_write <= w_is_write_cmd;
            r_addr     <= i_cpu_addr;
            r_wdata    <= i_cpu_wdata;
            r_cnt      <= CNT_WIDTH'(WAIT_CYCLES);
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_oob) begin
            r_state <= ST_ERR;
          end else begin
            if (!r_is_write) begin
              r_rdata <= w_sram_rdata;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE, ST_ERR: begin
          // Wait for the CPU to release the command before accepting another.
          if (w_is_none_cmd) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mobo_stat = WORD_WIDTH'(r_state);
  assign o_cpu_rdata = r_rdata;

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Directed self-checking bench: one responder with WAIT_CYCLES=2, one with 0.
module tb_mobo_mem_responder;

  localparam int W = 16;
  localparam logic [W-1:0] C_NONE = 16'd0, C_READ = 16'd1, C_WRITE = 16'd2;
  localparam logic [W-1:0] S_IDLE = 16'd0, S_BUSY = 16'd1, S_DONE = 16'd2, S_ERR = 16'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] c2 = '0, a2 = '0, w2 = '0, s2, r2;
  logic [W-1:0] c0 = '0, a0 = '0, w0 = '0, s0, r0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mobo_mem_responder #(
    .WORD_WIDTH  (W),
    .MEM_DEPTH   (256),
    .WAIT_CYCLES (2)
  ) dut2 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mobo_ctrl (c2),
    .o_mobo_stat (s2),
    .i_cpu_addr  (a2),
    .i_cpu_wdata (w2),
    .o_cpu_rdata (r2)
  );

  mobo_mem_responder #(
    .WORD_WIDTH  (W),
    .MEM_DEPTH   (256),
    .WAIT_CYCLES (0)
  ) dut0 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mobo_ctrl (c0),
    .o_mobo_stat (s0),
    .i_cpu_addr  (a0),
    .i_cpu_wdata (w0),
    .o_cpu_rdata (r0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the WAIT_CYCLES=2 responder: returns BUSY cycle count,
  // terminal status and read data in the first DONE/ERR cycle, then releases.
  task automatic op2(input logic [W-1:0] ctrl, input logic [W-1:0] addr,
                     input logic [W-1:0] wdata, output int busy,
                     output logic [W-1:0] fstat, output logic [W-1:0] frd);
    c2 = ctrl; a2 = addr; w2 = wdata;
    step();
    busy = 0;
    while (s2 === S_BUSY && busy < 20) begin
      busy++;
      step();
    end
    if (busy >= 20) begin
      n_vec++; n_err++;
      $display("FAIL op2_timeout: stat=%0d still busy, required completion", s2);
    end
    fstat = s2;
    frd   = r2;
    c2 = C_NONE;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if (s2 !== S_IDLE || r2 !== '0 || s0 !== S_IDLE || r0 !== '0) begin
      n_err++;
      $display("FAIL reset: stat2=%0d rd2=%0h stat0=%0d rd0=%0h, required 0/0/0/0",
               s2, r2, s0, r0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_timing();
    int busy;
    c2 = C_WRITE; a2 = 16'd3; w2 = 16'd5;
    busy = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      if (s2 === S_BUSY) busy++;
      step();
    end
    n_vec++;
    if (busy != 3) begin
      n_err++;
      $display("FAIL write_busy_len: busy cycles=%0d, required 3", busy);
    end
    n_vec++;
    if (s2 !== S_DONE) begin
      n_err++;
      $display("FAIL write_done_k4: stat=%0d, required %0d", s2, S_DONE);
    end
    c2 = C_NONE;
    step();
    n_vec++;
    if (s2 !== S_IDLE) begin
      n_err++;
      $display("FAIL write_release: stat=%0d, required %0d", s2, S_IDLE);
    end
  endtask

  task automatic test_read();
    int busy;
    logic [W-1:0] st, rd;
    op2(C_READ, 16'd3, 16'h0, busy, st, rd);
    n_vec++;
    if (st !== S_DONE || rd !== 16'd5 || busy != 3) begin
      n_err++;
      $display("FAIL read3: stat=%0d rdata=%0h busy=%0d, required 2/5/3", st, rd, busy);
    end
    op2(C_WRITE, 16'd3, 16'd9, busy, st, rd);
    n_vec++;
    if (st !== S_DONE || rd !== 16'd5 || r2 !== 16'd5) begin
      n_err++;
      $display("FAIL rdata_hold_after_write: stat=%0d rdata=%0h/%0h, required 2/5/5",
               st, rd, r2);
    end
    op2(C_READ, 16'd3, 16'h0, busy, st, rd);
    n_vec++;
    if (rd !== 16'd9) begin
      n_err++;
      $display("FAIL reread3: rdata=%0h, required 9", rd);
    end
  endtask

  task automatic test_error();
    int busy;
    logic [W-1:0] st, rd;
    op2(C_WRITE, 16'd0, 16'h11, busy, st, rd);
    op2(C_READ, 16'd256, 16'h0, busy, st, rd);
    n_vec++;
    if (st !== S_ERR || rd !== 16'd9 || busy != 3) begin
      n_err++;
      $display("FAIL read_oob: stat=%0d rdata=%0h busy=%0d, required 3/9/3", st, rd, busy);
    end
    op2(C_WRITE, 16'd256, 16'h77, busy, st, rd);
    n_vec++;
    if (st !== S_ERR) begin
      n_err++;
      $display("FAIL write_oob: stat=%0d, required %0d", st, S_ERR);
    end
    op2(C_READ, 16'h8001, 16'h0, busy, st, rd);
    n_vec++;
    if (st !== S_ERR || rd !== 16'd9) begin
      n_err++;
      $display("FAIL read_upper_bit: stat=%0d rdata=%0h, required 3/9", st, rd);
    end
    op2(C_READ, 16'd0, 16'h0, busy, st, rd);
    n_vec++;
    if (st !== S_DONE || rd !== 16'h11) begin
      n_err++;
      $display("FAIL mem0_untouched: stat=%0d rdata=%0h, required 2/11", st, rd);
    end
  endtask

  task automatic test_hold_and_ignore();
    int busy;
    logic [W-1:0] st, rd;
    int done_cnt;
    c2 = C_WRITE; a2 = 16'd4; w2 = 16'd7;
    step();
    // Inputs changing during BUSY must not affect the latched request.
    w2 = 16'd8; a2 = 16'd5;
    step();
    step();
    step();
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (s2 === S_DONE) done_cnt++;
      step();
    end
    n_vec++;
    if (done_cnt != 5) begin
      n_err++;
      $display("FAIL hold_done: done cycles=%0d, required 5", done_cnt);
    end
    c2 = C_NONE;
    step();
    op2(C_READ, 16'd4, 16'h0, busy, st, rd);
    n_vec++;
    if (rd !== 16'd7) begin
      n_err++;
      $display("FAIL latched_wdata: mem[4]=%0h, required 7", rd);
    end
  endtask

  task automatic test_reset_mid_busy();
    int busy;
    logic [W-1:0] st, rd;
    op2(C_WRITE, 16'd10, 16'h55, busy, st, rd);
    c2 = C_WRITE; a2 = 16'd10; w2 = 16'hAA;
    step();
    step();
    step();
    // Reset lands exactly on the edge that would have completed the write.
    rst = 1'b1;
    c2 = C_NONE;
    step();
    n_vec++;
    if (s2 !== S_IDLE || r2 !== '0) begin
      n_err++;
      $display("FAIL reset_mid_busy: stat=%0d rdata=%0h, required 0/0", s2, r2);
    end
    rst = 1'b0;
    step();
    op2(C_READ, 16'd10, 16'h0, busy, st, rd);
    n_vec++;
    if (rd !== 16'h55) begin
      n_err++;
      $display("FAIL aborted_write: mem[10]=%0h, required 55", rd);
    end
  endtask

  task automatic test_back_to_back();
    int idle_cnt;
    c0 = 16'd3; a0 = 16'd0; w0 = 16'h0;
    idle_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (s0 === S_IDLE) idle_cnt++;
    end
    n_vec++;
    if (idle_cnt != 3) begin
      n_err++;
      $display("FAIL unknown_ctrl: idle cycles=%0d, required 3", idle_cnt);
    end
    c0 = C_WRITE; a0 = 16'd0; w0 = 16'h3C;
    step();
    n_vec++;
    if (s0 !== S_BUSY) begin
      n_err++;
      $display("FAIL w0_busy: stat=%0d, required %0d", s0, S_BUSY);
    end
    step();
    n_vec++;
    if (s0 !== S_DONE || r0 !== '0) begin
      n_err++;
      $display("FAIL w0_done: stat=%0d rdata=%0h, required 2/0", s0, r0);
    end
    c0 = C_NONE;
    step();
    n_vec++;
    if (s0 !== S_IDLE) begin
      n_err++;
      $display("FAIL w0_idle: stat=%0d, required %0d", s0, S_IDLE);
    end
    c0 = C_READ; a0 = 16'd0;
    step();
    n_vec++;
    if (s0 !== S_BUSY) begin
      n_err++;
      $display("FAIL r0_busy: stat=%0d, required %0d", s0, S_BUSY);
    end
    step();
    n_vec++;
    if (s0 !== S_DONE || r0 !== 16'h3C) begin
      n_err++;
      $display("FAIL r0_done: stat=%0d rdata=%0h, required 2/3c", s0, r0);
    end
    c0 = C_NONE;
    step();
    n_vec++;
    if (s0 !== S_IDLE || r0 !== 16'h3C) begin
      n_err++;
      $display("FAIL r0_idle: stat=%0d rdata=%0h, required 0/3c", s0, r0);
    end
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_read();
    test_error();
    test_hold_and_ignore();
    test_reset_mid_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mobo_mem_responder.md
# mobo_mem_responder

Responder end of the CPU↔motherboard control/status handshake. Samples the CPU's `mobo_ctrl`, address and write-data outputs, performs one word read or write into an internal word-addressed memory after a configurable wait, and reports progress on `mobo_stat`. It is the memory-side counterpart the CPU's read/write states talk to; it returns read data on the bus the CPU latches into its data-in register.

## Interface
- `WORD_WIDTH`, default `` `WORD_WIDTH ``: width of ctrl, stat, address and data words.
- `MEM_DEPTH`, default 256: number of words; valid addresses are 0..MEM_DEPTH-1.
- `WAIT_CYCLES`, default 2: extra BUSY cycles before the access completes (0 allowed).
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `mobo_ctrl` in WORD_WIDTH: command from CPU; `CTRL_NONE`=0, `CTRL_READ`=1, `CTRL_WRITE`=2, other values ignored.
- `mobo_stat` out WORD_WIDTH: `STAT_IDLE`=0, `STAT_BUSY`=1, `STAT_DONE`=2, `STAT_ERR`=3.
- `cpu_addr` in WORD_WIDTH: word address from CPU address register.
- `cpu_wdata` in WORD_WIDTH: write data from CPU data-out register.
- `cpu_rdata` out WORD_WIDTH: read data to CPU data-in register.

## Operation
- FSM states: IDLE, BUSY, DONE, ERR. `mobo_stat` is registered and equals the state encoding.
- IDLE: on `mobo_ctrl` ∈ {READ, WRITE}, latch op, `cpu_addr`, `cpu_wdata`; load wait counter with WAIT_CYCLES; go BUSY. NONE or unknown codes: stay IDLE.
- BUSY: counter decrements each cycle; while counter ≠ 0 stay BUSY. When counter = 0:
  - latched addr ≥ MEM_DEPTH (any upper bit set included): no memory access, `cpu_rdata` unchanged, go ERR.
  - WRITE: mem[addr] ← latched wdata, go DONE.
  - READ: `cpu_rdata` ← mem[addr], go DONE.
- DONE/ERR: hold until `mobo_ctrl` = NONE, then go IDLE. A READ/WRITE still asserted is never re-triggered (four-phase handshake).
- Changes on `mobo_ctrl`, `cpu_addr`, `cpu_wdata` during BUSY are ignored; latched values rule.
- `cpu_rdata` holds its value until the next successful read; writes do not change it.
- Reset: state → IDLE, `mobo_stat` = `STAT_IDLE`, `cpu_rdata` = 0, counter = 0. Reset mid-BUSY aborts the operation with no memory write. Memory array contents are not cleared by reset.

## Timing
- Command sampled at edge k (state IDLE) → `mobo_stat` = BUSY from cycle k+1.
- BUSY lasts exactly WAIT_CYCLES+1 cycles; DONE/ERR visible from cycle k+WAIT_CYCLES+2, `cpu_rdata` valid in the same cycle DONE appears.
- NONE sampled at edge m in DONE/ERR → IDLE from cycle m+1; earliest next command accepted at edge m+1.
- Minimum round trip with WAIT_CYCLES=0: IDLE→BUSY→DONE→IDLE = 3 cycles plus CPU release.
- Address index = `cpu_addr[$clog2(MEM_DEPTH)-1:0]` after the range check; no wrap-around.

## Structure
- Shared package `mobo_pkg`: CTRL_* and STAT_* constants (shared with the CPU's `mobo_states` definitions, same values), responder state enum.
- One sub-module: `mobo_sram` — single-port synchronous word RAM (clk, we, addr, wdata, rdata), no reset on the array. Responder FSM, counter and latches live in `mobo_mem_responder`.

## Test plan
- Reset, WAIT_CYCLES=2: WRITE addr 3 data 5, hold ctrl until DONE → BUSY exactly 3 cycles, DONE at k+4; drop to NONE → IDLE next cycle.
- After above, READ addr 3 → `cpu_rdata` = 5 in the first DONE cycle; held at 5 after a subsequent WRITE to addr 3 of 9.
- READ addr MEM_DEPTH (256) → ERR, `cpu_rdata` unchanged; WRITE addr 256 → ERR, mem[0] unchanged.
- Hold ctrl = WRITE through DONE for 5 cycles → stays DONE, single write; change `cpu_wdata` from 7 to 8 during BUSY → mem holds 7.
- Assert `rst` during BUSY of WRITE addr 10 data 0xAA → IDLE/`STAT_IDLE`/`cpu_rdata`=0 next cycle; later READ addr 10 returns prior contents, not 0xAA.
- WAIT_CYCLES=0: ctrl = 3 (unknown) in IDLE → stays IDLE; back-to-back WRITE/NONE/READ of addr 0 → 3-cycle round trips, read returns written value.
